dram_arb: RTL

Parametrised DRAM port arbiter between the caches and the single DRAM controller.
- Takes NUM_RD cache refill read channels (channel 0 = I_Cache, channel 1 = D_Cache by default) and one write-back channel (D_Cache).
- Grants the DRAM port for one whole BLOCK_SIZE-word burst at a time.
- Supports selectable fixed-priority or round-robin read arbitration.
- Write-back always wins over reads, so a dirty line is written before its refill.

---
 rtl/dram_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dram_arb.sv
// DRAM port arbiter: grants the single DRAM controller port to either the
// write-back channel or one of NUM_RD refill read channels, one whole burst at a time.
module dram_arb #(
  parameter  int NUM_RD     = 2,
  parameter  int BLOCK_SIZE = 8,
  parameter  int AW         = 32,
  parameter  int DW         = 32,
  parameter  int RR_MODE    = 1,
  localparam int GW         = (NUM_RD > 1) ? $clog2(NUM_RD) : 1,
  localparam int CW         = $clog2(BLOCK_SIZE)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_RD-1:0]    rd_req,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic [NUM_RD-1:0]    rd_val,
  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic                 wr_val,
  output logic                 dram_rd_req,
  output logic [AW-1:0]        dram_rd_addr,
  input  logic [DW-1:0]        dram_rd_data,
  input  logic                 dram_rd_val,
  output logic                 dram_wr_req,
  output logic [AW-1:0]        dram_wr_addr,
  output logic [DW-1:0]        dram_wr_data,
  input  logic                 dram_wr_val,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  logic          beat;
  logic          last_beat;

  // Round-robin searches upward from the channel after the last grant and wraps;
  // fixed priority simply scans from channel 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (RR_MODE != 0) cand = GW'((int'(last_q) + 1 + k) % NUM_RD);
      else              cand = GW'(k);
      if (!found && rd_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign beat      = ((state_q == RD) && dram_rd_val) || ((state_q == WR) && dram_wr_val);
  assign last_beat = beat && (cnt_q == CW'(BLOCK_SIZE - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Write-back wins so a dirty line reaches DRAM before its refill.
        if (wr_req) begin
          state_d   = WR;
          wr_addr_d = wr_addr;
        end else if (found) begin
          state_d = RD;
          grant_d = winner;
          last_d  = winner;
          for (int i = 0; i < NUM_RD; i++) begin
            if (winner == GW'(i)) rd_addr_d = rd_addr[i*AW +: AW];
          end
        end
      end
      WR, RD: begin
        if (last_beat) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      last_q    <= GW'(NUM_RD - 1);
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = dram_rd_val && (state_q == RD) && (grant_q == GW'(i));
    end
  end

  assign rd_data      = dram_rd_data;
  assign wr_val       = dram_wr_val && (state_q == WR);
  assign dram_wr_data = wr_data;
  assign dram_rd_req  = (state_q == RD);
  assign dram_wr_req  = (state_q == WR);
  assign dram_rd_addr = rd_addr_q;
  assign dram_wr_addr = wr_addr_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);

endmodule
